// File: rtl/global_pkg.sv
// Shared definitions for the wb_ram slave: Wishbone cycle-type codes, the
// slave state enum and an address window check.
//   CTI_CLASSIC / CTI_INCR / CTI_EOB : Wishbone CTI_I encodings
//   wb_ram_state_t                   : IDLE, WAIT, RESP, BURST
//   addr_ok()                        : word-aligned and inside [base, base+span)
package global_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    BURST = 2'd3
  } wb_ram_state_t;

  // span is 33 bits so that a window reaching the top of the 32-bit space
  // still compares correctly.
  function automatic logic addr_ok(input logic [31:0] adr,
                                   input logic [31:0] base,
                                   input logic [32:0] span);
    logic [31:0] off;
    off = adr - base;
    return (adr[1:0] == 2'b00) && ({1'b0, off} < span);
  endfunction

endpackage

// File: rtl/wb_ram_array.sv
// Single-port synchronous RAM, 32-bit words, registered read, write enable.
// Ports:
//   clk, rst : clock; async active-high reset (clears only the read register)
//   en       : access enable for this cycle
//   we       : 1 = write wdata to addr, 0 = read addr into rdata
//   addr     : word index
//   wdata    : write data
//   rdata    : registered read data, holds its value when no read is issued
// Contents are not cleared by reset.
module wb_ram_array #(
  parameter int    DEPTH_WORDS = 4096,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_ram.sv
// Wishbone B4 slave in front of a word-addressed on-chip RAM.
// Ports:
//   clk, rst      : clock; asynchronous active-high reset
//   CYC, STB, WE  : Wishbone cycle, strobe, write enable
//   ADR           : byte address
//   DAT_I         : write data
//   CTI_I         : cycle type (classic / incrementing / end-of-burst)
//   DAT_O         : registered read data, valid while ACK=1
//   ACK, ERR      : transfer complete / rejected (never together)
//   RTY           : constant 0
// Build option: define WB_RAM_BURST_EN to serve incrementing bursts; without
// it CTI_I is ignored and every transfer is classic.
//
// state | meaning
// IDLE  | waiting for CYC&STB, request is latched when seen
// WAIT  | counting wait states (stalls while STB is low)
// RESP  | one-cycle ACK or ERR for the latched request
// BURST | one beat per cycle at consecutive word addresses
module wb_ram
  import global_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CYC,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADR,
  input  logic [31:0] DAT_I,
  input  logic [2:0]  CTI_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  output logic        ERR,
  output logic        RTY
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  wb_ram_state_t state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [31:0]   adr_q, adr_n;
  logic          we_q, we_n;
  logic [31:0]   dat_q, dat_n;

  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;

  logic          beat_err;
  logic [31:0]   adr_inc;

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

`ifndef WB_RAM_BURST_EN
  logic unused_cti;
  assign unused_cti = ^CTI_I;
`endif

  // In RESP and BURST adr_q is the address of the beat on the bus.
  assign beat_err = !addr_ok(adr_q, BASE_ADDR, SPAN);
  assign adr_inc  = adr_q + 32'd4;
  assign RTY      = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      adr_q <= '0;
      we_q  <= 1'b0;
      dat_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      adr_q <= adr_n;
      we_q  <= we_n;
      dat_q <= dat_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    adr_n     = adr_q;
    we_n      = we_q;
    dat_n     = dat_q;
    ACK       = 1'b0;
    ERR       = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = word_idx(adr_q);
    ram_wdata = dat_q;

    case (state)
      IDLE: begin
        if (CYC && STB) begin
          adr_n = ADR;
          we_n  = WE;
          dat_n = DAT_I;
          if (WAIT_STATES > 0) begin
            cnt_n   = 4'(WAIT_STATES - 1);
            state_n = WAIT;
          end else begin
            // No wait states: the read must be issued from the live address
            // so DAT_O is ready in the ACK cycle.
            state_n  = RESP;
            ram_en   = 1'b1;
            ram_addr = word_idx(ADR);
          end
        end
      end

      WAIT: begin
        if (!CYC) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (STB) begin
          if (cnt == 4'd0) begin
            state_n = RESP;
            ram_en  = 1'b1;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
      end

      RESP: begin
        state_n = IDLE;
        if (CYC) begin
          ACK = !beat_err;
          ERR = beat_err;
          if (we_q && !beat_err) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
          end
`ifdef WB_RAM_BURST_EN
          if (STB && (CTI_I == CTI_INCR) && !beat_err) begin
            state_n = BURST;
            adr_n   = adr_inc;
            // The single port is busy with the write on write bursts, so only
            // read bursts prefetch; WE is expected constant within a burst.
            if (!we_q) begin
              ram_en   = 1'b1;
              ram_addr = word_idx(adr_inc);
            end
          end
`endif
        end
      end

`ifdef WB_RAM_BURST_EN
      BURST: begin
        if (!CYC) begin
          state_n = IDLE;
        end else if (STB) begin
          we_n  = WE;
          dat_n = DAT_I;
          ACK   = !beat_err;
          ERR   = beat_err;
          if (WE && !beat_err) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_wdata = DAT_I;
          end
          if (beat_err || (CTI_I != CTI_INCR)) begin
            state_n = IDLE;
          end else begin
            adr_n = adr_inc;
            if (!WE) begin
              ram_en   = 1'b1;
              ram_addr = word_idx(adr_inc);
            end
          end
        end
      end
`endif

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  wb_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (DAT_O)
  );

endmodule
